// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the iterative multiply/divide unit.
// Build option: MULTDIV_EARLY_DONE_EN (trivial operands finish after one step).
package multdiv_pkg;
  localparam int WIDTH = 32;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/multdiv_unit_booth_step.sv
// One radix-2 Booth iteration on the {A, Q, q-1} accumulator.
module booth_step
  import multdiv_pkg::*;
(
  input  logic [2*WIDTH:0] i_acc,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [2*WIDTH:0] o_acc
);
  logic [WIDTH:0] w_a, w_m, w_sum;

  // Sum kept one bit wider so the shift uses the true sign when A +/- M overflows WIDTH bits.
  assign w_a = {i_acc[2*WIDTH], i_acc[2*WIDTH:WIDTH+1]};
  assign w_m = {i_mcand[WIDTH-1], i_mcand};

  always_comb begin
    w_sum = w_a;
    case (i_acc[1:0])
      2'b01:   w_sum = w_a + w_m;
      2'b10:   w_sum = w_a - w_m;
      default: w_sum = w_a;
    endcase
  end

  assign o_acc = {w_sum, i_acc[WIDTH:1]};
endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply (Booth) / divide (restoring on magnitudes).
// Build option: MULTDIV_EARLY_DONE_EN skips iteration for zero operands / zero divisor.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH:0]   r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvsr;
  logic             r_neg, r_dzero, r_ovf;
  logic [WIDTH-1:0] r_result;
  logic             r_exc, r_rdy, r_busy;
`ifdef MULTDIV_EARLY_DONE_EN
  logic             r_early;
`endif

  logic             w_start, w_last;
  logic [2*WIDTH:0] w_acc_nxt;
  logic             w_mul_exc;
  logic [WIDTH-1:0] w_absA, w_absB;
  logic [WIDTH+1:0] w_rem_sh, w_diff;
  logic [WIDTH:0]   w_rem_nxt;
  logic [WIDTH-1:0] w_quo_nxt, w_quo_fin;

  assign w_start = ctrl_MULT | ctrl_DIV;
  assign w_last  = (r_cnt == CNT_W'(WIDTH-1));

  booth_step u_booth (
    .i_acc   (r_acc),
    .i_mcand (r_mcand),
    .o_acc   (w_acc_nxt)
  );

  assign w_mul_exc = (w_acc_nxt[2*WIDTH:WIDTH+1] != {WIDTH{w_acc_nxt[WIDTH]}});

  // Magnitude of INT_MIN wraps to 0x80000000, which is correct read as unsigned.
  assign w_absA = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_absB = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  assign w_rem_sh  = {r_rem, r_quo[WIDTH-1]};
  assign w_diff    = w_rem_sh - {2'b00, r_dvsr};
  assign w_rem_nxt = w_diff[WIDTH+1] ? w_rem_sh[WIDTH:0] : w_diff[WIDTH:0];
  assign w_quo_nxt = {r_quo[WIDTH-2:0], ~w_diff[WIDTH+1]};
  assign w_quo_fin = r_neg ? (~w_quo_nxt + WIDTH'(1)) : w_quo_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvsr   <= '0;
      r_neg    <= 1'b0;
      r_dzero  <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
      r_busy   <= 1'b0;
`ifdef MULTDIV_EARLY_DONE_EN
      r_early  <= 1'b0;
`endif
    end else if (w_start) begin
      // A start in any state (including mid-operation) discards the previous work.
      r_state <= ctrl_MULT ? MULT : DIV;
      r_cnt   <= '0;
      r_busy  <= 1'b1;
      r_rdy   <= 1'b0;
      r_exc   <= 1'b0;
      r_acc   <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      r_mcand <= data_operandA;
      r_rem   <= '0;
      r_quo   <= w_absA;
      r_dvsr  <= w_absB;
      r_neg   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_dzero <= ~ctrl_MULT & (data_operandB == '0);
      r_ovf   <= ~ctrl_MULT & (data_operandA == INT_MIN) & (data_operandB == '1);
`ifdef MULTDIV_EARLY_DONE_EN
      r_early <= ctrl_MULT ? ((data_operandA == '0) | (data_operandB == '0))
                           : (data_operandB == '0);
`endif
    end else begin
      case (r_state)
        MULT: begin
`ifdef MULTDIV_EARLY_DONE_EN
          if (r_early) begin
            r_result <= '0;
            r_exc    <= 1'b0;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end else begin
`else
          begin
`endif
            r_acc <= w_acc_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= w_acc_nxt[WIDTH:1];
              r_exc    <= w_mul_exc;
              r_rdy    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
        end
        DIV: begin
`ifdef MULTDIV_EARLY_DONE_EN
          if (r_early) begin
            r_result <= '0;
            r_exc    <= 1'b1;
            r_rdy    <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= DONE;
          end else begin
`else
          begin
`endif
            r_rem <= w_rem_nxt;
            r_quo <= w_quo_nxt;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
              r_result <= r_dzero ? '0 : w_quo_fin;
              r_exc    <= r_dzero | r_ovf;
              r_rdy    <= 1'b1;
              r_busy   <= 1'b0;
              r_state  <= DONE;
            end
          end
        end
        DONE: begin
          r_rdy   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_rdy <= 1'b0;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;
  assign data_resultRDY = r_rdy;
  assign busy           = r_busy;
endmodule
